// File: rtl/apb_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : apb_pkg
//  Description : Shared APB types and default widths for the APB requester
//                bridge and its companion slave benches.
//  Revision    : 1.0 - initial release
// ============================================================================
package apb_pkg;

    // Requester FSM states
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2,
        RESP   = 2'd3
    } apb_state_e;

    // Default bus widths, shared with APB_Slave benches
    localparam int APB_ADDR_W = 8;
    localparam int APB_DATA_W = 32;

endpackage : apb_pkg
`default_nettype wire

// File: rtl/apb_master.sv
`default_nettype none
// ============================================================================
//  Module      : apb_master
//  Description : APB requester bridge. Converts a valid/ready command stream
//                into APB SETUP/ACCESS transfers and returns one response
//                (rdata, error) per command. One transfer in flight; PREADY
//                wait states honoured; optional ACCESS-phase timeout.
//  Revision    : 1.0 - initial release
// ============================================================================
module apb_master
    import apb_pkg::*;
#(
    parameter int ADDR_WIDTH     = APB_ADDR_W,
    parameter int DATA_WIDTH     = APB_DATA_W,
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic                  PCLK,
    input  logic                  PRESETn,
    // command port
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic                  cmd_write,
    input  logic [ADDR_WIDTH-1:0] cmd_addr,
    input  logic [DATA_WIDTH-1:0] cmd_wdata,
    // response port
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [DATA_WIDTH-1:0] rsp_rdata,
    output logic                  rsp_error,
    // APB requester interface
    output logic                  PSEL,
    output logic                  PENABLE,
    output logic                  PWRITE,
    output logic [ADDR_WIDTH-1:0] PADDR,
    output logic [DATA_WIDTH-1:0] PWDATA,
    input  logic [DATA_WIDTH-1:0] PRDATA,
    input  logic                  PREADY,
    input  logic                  PSLVERR
);

    apb_state_e r_state;
    apb_state_e w_state_next;

    logic                  r_psel;
    logic                  r_penable;
    logic                  r_pwrite;
    logic [ADDR_WIDTH-1:0] r_paddr;
    logic [DATA_WIDTH-1:0] r_pwdata;
    logic                  r_rsp_valid;
    logic [DATA_WIDTH-1:0] r_rsp_rdata;
    logic                  r_rsp_error;

    logic w_accept;
    logic w_complete;
    logic w_timeout;

    assign w_accept   = (r_state == IDLE) && cmd_valid;
    assign w_complete = (r_state == ACCESS) && PREADY;

    // Watchdog: counts PREADY-low ACCESS edges; expiry fires on the edge that
    // would bring the count to TIMEOUT_CYCLES. A completing edge never expires
    // because expiry requires PREADY low.
    if (TIMEOUT_CYCLES > 0) begin : g_timeout
        localparam int              c_TO_W    = $clog2(TIMEOUT_CYCLES + 1);
        localparam logic [c_TO_W-1:0] c_TO_LAST = c_TO_W'(TIMEOUT_CYCLES - 1);

        logic [c_TO_W-1:0] r_to_cnt;

        // Clear on the way into ACCESS, count stalled ACCESS edges
        always_ff @(posedge PCLK or negedge PRESETn) begin
            if (!PRESETn) begin
                r_to_cnt <= '0;
            end else if (r_state == SETUP) begin
                r_to_cnt <= '0;
            end else if ((r_state == ACCESS) && !PREADY) begin
                r_to_cnt <= r_to_cnt + c_TO_W'(1);
            end
        end

        assign w_timeout = (r_state == ACCESS) && !PREADY && (r_to_cnt == c_TO_LAST);
    end else begin : g_no_timeout
        assign w_timeout = 1'b0;
    end

    // State register
    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state decode
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            IDLE:    if (cmd_valid) w_state_next = SETUP;
            SETUP:   w_state_next = ACCESS;
            ACCESS:  if (PREADY || w_timeout) w_state_next = RESP;
            RESP:    if (rsp_ready) w_state_next = IDLE;
            default: w_state_next = IDLE;
        endcase
    end

    // Registered APB and response outputs; address/data hold after a transfer
    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            r_psel      <= 1'b0;
            r_penable   <= 1'b0;
            r_pwrite    <= 1'b0;
            r_paddr     <= '0;
            r_pwdata    <= '0;
            r_rsp_valid <= 1'b0;
            r_rsp_rdata <= '0;
            r_rsp_error <= 1'b0;
        end else begin
            if (w_accept) begin
                r_paddr   <= cmd_addr;
                r_pwrite  <= cmd_write;
                r_pwdata  <= cmd_wdata;
                r_psel    <= 1'b1;
                r_penable <= 1'b0;
            end
            if (r_state == SETUP) begin
                r_penable <= 1'b1;
            end
            if (w_complete) begin
                r_psel      <= 1'b0;
                r_penable   <= 1'b0;
                r_rsp_valid <= 1'b1;
                r_rsp_error <= PSLVERR;
                r_rsp_rdata <= r_pwrite ? '0 : PRDATA;
            end else if (w_timeout) begin
                r_psel      <= 1'b0;
                r_penable   <= 1'b0;
                r_rsp_valid <= 1'b1;
                r_rsp_error <= 1'b1;
                r_rsp_rdata <= '0;
            end
            if ((r_state == RESP) && rsp_ready) begin
                r_rsp_valid <= 1'b0;
            end
        end
    end

    assign cmd_ready = (r_state == IDLE);
    assign PSEL      = r_psel;
    assign PENABLE   = r_penable;
    assign PWRITE    = r_pwrite;
    assign PADDR     = r_paddr;
    assign PWDATA    = r_pwdata;
    assign rsp_valid = r_rsp_valid;
    assign rsp_rdata = r_rsp_rdata;
    assign rsp_error = r_rsp_error;

endmodule : apb_master
`default_nettype wire

// File: tb/tb_apb_master.sv
`default_nettype none
// ============================================================================
//  Module      : tb_apb_master
//  Description : Directed self-checking bench for apb_master with a simple
//                memory slave model offering wait states, stuck-low PREADY
//                and PSLVERR injection.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_apb_master;

    logic        PCLK;
    logic        PRESETn;
    logic        cmd_valid;
    logic        cmd_ready;
    logic        cmd_write;
    logic [7:0]  cmd_addr;
    logic [31:0] cmd_wdata;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_rdata;
    logic        rsp_error;
    logic        PSEL;
    logic        PENABLE;
    logic        PWRITE;
    logic [7:0]  PADDR;
    logic [31:0] PWDATA;
    logic [31:0] PRDATA;
    logic        PREADY;
    logic        PSLVERR;

    int n_tests = 0;
    int n_fail  = 0;

    // slave model controls
    int   waits    = 0;
    int   wcnt     = 0;
    logic stuck    = 1'b0;
    logic err_mode = 1'b0;
    logic [31:0] mem [256];

    apb_master #(
        .ADDR_WIDTH     (8),
        .DATA_WIDTH     (32),
        .TIMEOUT_CYCLES (4)
    ) u_dut (
        .PCLK      (PCLK),
        .PRESETn   (PRESETn),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_write (cmd_write),
        .cmd_addr  (cmd_addr),
        .cmd_wdata (cmd_wdata),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_rdata (rsp_rdata),
        .rsp_error (rsp_error),
        .PSEL      (PSEL),
        .PENABLE   (PENABLE),
        .PWRITE    (PWRITE),
        .PADDR     (PADDR),
        .PWDATA    (PWDATA),
        .PRDATA    (PRDATA),
        .PREADY    (PREADY),
        .PSLVERR   (PSLVERR)
    );

    initial PCLK = 1'b0;
    always #5 PCLK = ~PCLK;

    // Slave model: PREADY asserts after 'waits' low ACCESS cycles
    assign PREADY  = !stuck && (wcnt >= waits);
    assign PRDATA  = mem[PADDR];
    assign PSLVERR = err_mode && PSEL && PENABLE;

    always @(posedge PCLK) begin
        if (PSEL && PENABLE && !PREADY) wcnt <= wcnt + 1;
        else                            wcnt <= 0;
        if (PSEL && PENABLE && PREADY && PWRITE) mem[PADDR] <= PWDATA;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // One full command/response exchange with rsp_ready held high.
    // lat = negedges from accept until rsp_valid seen; pen = PENABLE-high samples.
    task automatic xfer(input logic w, input logic [7:0] a, input logic [31:0] d,
                        output logic [31:0] rd, output logic er,
                        output int lat, output int pen, output logic stable);
        int k;
        @(negedge PCLK);
        cmd_valid = 1'b1; cmd_write = w; cmd_addr = a; cmd_wdata = d;
        rsp_ready = 1'b1;
        k = 0;
        while (!cmd_ready && k < 20) begin
            @(negedge PCLK);
            k++;
        end
        if (!cmd_ready) chk("cmd_ready_wait", 32'd0, 32'd1);
        @(posedge PCLK);
        #1;
        // scramble the command bus: must not affect the accepted transfer
        cmd_valid = 1'b0; cmd_write = ~w; cmd_addr = ~a; cmd_wdata = ~d;
        lat = 0; pen = 0; stable = 1'b1; rd = '0; er = 1'b0;
        for (int i = 1; i <= 40; i++) begin
            @(negedge PCLK);
            if (PENABLE) pen++;
            if (PSEL && (PADDR !== a || PWRITE !== w || (w && PWDATA !== d))) stable = 1'b0;
            if (rsp_valid) begin
                lat = i;
                break;
            end
        end
        if (lat == 0) chk("rsp_wait", 32'd0, 32'd1);
        rd = rsp_rdata;
        er = rsp_error;
    endtask

    logic [31:0] rd;
    logic        er;
    int          lat;
    int          pen;
    logic        stable;

    logic [7:0]  va [4] = '{8'h01, 8'h80, 8'hFF, 8'h5A};
    logic [31:0] vd [4] = '{32'h0000_0001, 32'hA5A5_5A5A, 32'hFFFF_FFFF, 32'h1357_9BDF};

    initial begin
        PRESETn   = 1'b0;
        cmd_valid = 1'b0;
        cmd_write = 1'b0;
        cmd_addr  = '0;
        cmd_wdata = '0;
        rsp_ready = 1'b0;

        // ---- reset state
        #2;
        chk("rst_psel",      {31'd0, PSEL},      32'd0);
        chk("rst_penable",   {31'd0, PENABLE},   32'd0);
        chk("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
        chk("rst_rsp_rdata", rsp_rdata,          32'd0);
        chk("rst_rsp_error", {31'd0, rsp_error}, 32'd0);
        chk("rst_cmd_ready", {31'd0, cmd_ready}, 32'd1);
        repeat (3) @(negedge PCLK);
        PRESETn = 1'b1;

        // ---- 1: write 0x3C with exact phase timing
        @(negedge PCLK);
        cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 8'h3C; cmd_wdata = 32'hDEAD_BEEF;
        rsp_ready = 1'b1;
        chk("t1_cmd_ready", {31'd0, cmd_ready}, 32'd1);
        @(posedge PCLK);
        #1 cmd_valid = 1'b0;
        @(negedge PCLK);
        chk("t1_psel_e0",    {31'd0, PSEL},    32'd1);
        chk("t1_penable_e0", {31'd0, PENABLE}, 32'd0);
        chk("t1_paddr",      {24'd0, PADDR},   32'h3C);
        chk("t1_pwdata",     PWDATA,           32'hDEAD_BEEF);
        chk("t1_cmd_ready_busy", {31'd0, cmd_ready}, 32'd0);
        @(negedge PCLK);
        chk("t1_penable_e1", {31'd0, PENABLE}, 32'd1);
        @(negedge PCLK);
        chk("t1_rsp_valid",  {31'd0, rsp_valid}, 32'd1);
        chk("t1_rsp_error",  {31'd0, rsp_error}, 32'd0);
        chk("t1_rsp_rdata",  rsp_rdata,          32'd0);
        chk("t1_psel_done",  {31'd0, PSEL},      32'd0);
        @(negedge PCLK);
        chk("t1_rsp_valid_clr", {31'd0, rsp_valid}, 32'd0);
        chk("t1_cmd_ready_idle", {31'd0, cmd_ready}, 32'd1);
        chk("t1_paddr_hold", {24'd0, PADDR}, 32'h3C);

        // ---- 2: read back, then write/read pairs
        xfer(1'b0, 8'h3C, 32'h0, rd, er, lat, pen, stable);
        chk("t2_rdata_3c", rd, 32'hDEAD_BEEF);
        chk("t2_err_3c",   {31'd0, er}, 32'd0);
        chk("t2_lat_3c",   lat, 32'd3);
        for (int i = 0; i < 4; i++) begin
            xfer(1'b1, va[i], vd[i], rd, er, lat, pen, stable);
            chk("t2_wr_rdata", rd, 32'd0);
            xfer(1'b0, va[i], 32'h0, rd, er, lat, pen, stable);
            chk("t2_rd_rdata", rd, vd[i]);
            chk("t2_rd_err",   {31'd0, er}, 32'd0);
        end

        // ---- 3: three wait states
        waits = 3;
        xfer(1'b1, 8'h44, 32'h0BAD_F00D, rd, er, lat, pen, stable);
        chk("t3_pen_cycles", pen, 32'd4);
        chk("t3_latency",    lat, 32'd6);
        chk("t3_stable",     {31'd0, stable}, 32'd1);
        chk("t3_err",        {31'd0, er}, 32'd0);
        xfer(1'b0, 8'h44, 32'h0, rd, er, lat, pen, stable);
        chk("t3_rd_rdata",   rd, 32'h0BAD_F00D);
        waits = 0;

        // ---- 4: timeout, then slave error
        stuck = 1'b1;
        xfer(1'b0, 8'h3C, 32'h0, rd, er, lat, pen, stable);
        chk("t4_to_err",     {31'd0, er}, 32'd1);
        chk("t4_to_rdata",   rd, 32'd0);
        chk("t4_to_psel",    {31'd0, PSEL}, 32'd0);
        chk("t4_to_latency", lat, 32'd6);
        chk("t4_to_pen",     pen, 32'd4);
        stuck = 1'b0;
        err_mode = 1'b1;
        xfer(1'b1, 8'h10, 32'h1111_2222, rd, er, lat, pen, stable);
        chk("t4_slverr",     {31'd0, er}, 32'd1);
        err_mode = 1'b0;
        xfer(1'b0, 8'h3C, 32'h0, rd, er, lat, pen, stable);
        chk("t4_err_clear",  {31'd0, er}, 32'd0);

        // ---- 5: response backpressure with cmd_valid held
        @(negedge PCLK);
        rsp_ready = 1'b0;
        cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 8'h3C; cmd_wdata = '0;
        @(posedge PCLK);
        #1;
        cmd_write = 1'b1; cmd_addr = 8'h55; cmd_wdata = 32'h1234_5678;
        begin : wait_rsp5
            int k;
            k = 0;
            @(negedge PCLK);
            while (!rsp_valid && k < 20) begin
                @(negedge PCLK);
                k++;
            end
        end
        chk("t5_rsp_valid", {31'd0, rsp_valid}, 32'd1);
        for (int i = 0; i < 5; i++) begin
            @(negedge PCLK);
            chk("t5_hold_valid", {31'd0, rsp_valid}, 32'd1);
            chk("t5_hold_rdata", rsp_rdata, 32'hDEAD_BEEF);
            chk("t5_cmd_ready",  {31'd0, cmd_ready}, 32'd0);
            chk("t5_no_psel",    {31'd0, PSEL}, 32'd0);
        end
        rsp_ready = 1'b1;
        @(negedge PCLK);
        chk("t5_after_hs_ready", {31'd0, cmd_ready}, 32'd1);
        chk("t5_after_hs_valid", {31'd0, rsp_valid}, 32'd0);
        @(negedge PCLK);
        chk("t5_next_psel",  {31'd0, PSEL}, 32'd1);
        chk("t5_next_paddr", {24'd0, PADDR}, 32'h55);
        cmd_valid = 1'b0;
        repeat (3) @(negedge PCLK);
        xfer(1'b0, 8'h55, 32'h0, rd, er, lat, pen, stable);
        chk("t5_next_rdata", rd, 32'h1234_5678);

        // ---- 6: asynchronous reset during ACCESS
        stuck = 1'b1;
        @(negedge PCLK);
        cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 8'h20; cmd_wdata = 32'h9999_9999;
        @(posedge PCLK);
        #1 cmd_valid = 1'b0;
        @(negedge PCLK);
        @(negedge PCLK);
        chk("t6_in_access", {31'd0, PENABLE}, 32'd1);
        #2 PRESETn = 1'b0;
        #1;
        chk("t6_psel",      {31'd0, PSEL},      32'd0);
        chk("t6_penable",   {31'd0, PENABLE},   32'd0);
        chk("t6_rsp_valid", {31'd0, rsp_valid}, 32'd0);
        stuck = 1'b0;
        repeat (2) @(negedge PCLK);
        PRESETn = 1'b1;
        @(negedge PCLK);
        chk("t6_cmd_ready", {31'd0, cmd_ready}, 32'd1);
        xfer(1'b1, 8'h77, 32'hCAFE_F00D, rd, er, lat, pen, stable);
        chk("t6_wr_err", {31'd0, er}, 32'd0);
        xfer(1'b0, 8'h77, 32'h0, rd, er, lat, pen, stable);
        chk("t6_rd_rdata", rd, 32'hCAFE_F00D);
        chk("t6_rd_err",   {31'd0, er}, 32'd0);

        @(negedge PCLK);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    // Global watchdog so the run always ends
    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule : tb_apb_master
`default_nettype wire
